// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding, constants and PC helpers for the fetch stage
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory request/response port (req/ready + rvalid)
interface fetch_stage_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: single outstanding request, one-entry output buffer
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_f,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  fetch_stage_if.master        imem,
  output logic [31:0]          Instr,
  output logic [31:0]          PC,
  output logic [31:0]          PC_plus4,
  output logic                 instr_valid,
  output logic                 misalign_err
);

  import fetch_pkg::*;

  fetch_state_t state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         kill_q, kill_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pc_plus4_q, pc_plus4_d;
  logic         valid_q, valid_d;
  logic         misalign_q, misalign_d;

  logic         redirect_act;
  logic         buf_free;
  logic         accept;
  logic         resp;
  logic         capture;
  logic [31:0]  target;

  // Redirect is ignored in IDLE: nothing has been issued yet and the first fetch is pending.
  assign redirect_act = redirect && (state_q != IDLE);
  assign target       = word_align(redirect_pc);
  assign buf_free     = !valid_q || !stall_f;
  assign accept       = (state_q == REQ) && imem.imem_ready;
  assign resp         = (state_q == WAIT) && imem.imem_rvalid;
  assign capture      = resp && !kill_q && !redirect_act && buf_free;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ:  if (accept) state_d = WAIT;
      // A held response leaves WAIT only once it is dropped or the buffer can take it.
      WAIT: if (resp && (kill_q || redirect_act || buf_free)) state_d = REQ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      kill_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      kill_q     <= kill_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    kill_d     = kill_q;
    misalign_d = redirect_act && (redirect_pc[1:0] != 2'b00);
    if (redirect_act) begin
      fetch_pc_d = target;
      // Something is still owed by memory unless this cycle's response is the one being dropped.
      kill_d     = accept || ((state_q == WAIT) && !imem.imem_rvalid);
    end else if (resp && kill_q) begin
      kill_d     = 1'b0;
    end else if (capture) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q    <= NOP_INSTR;
      pc_q       <= RESET_PC;
      pc_plus4_q <= RESET_PC + PC_STEP;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (redirect_act) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (capture) begin
      instr_d    = imem.imem_rdata;
      pc_d       = fetch_pc_q;
      pc_plus4_d = fetch_pc_q + PC_STEP;
      valid_d    = 1'b1;
    end else if (valid_q && !stall_f) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  assign imem.imem_req  = (state_q == REQ);
  assign imem.imem_addr = fetch_pc_q;
  assign Instr          = instr_q;
  assign PC             = pc_q;
  assign PC_plus4       = pc_plus4_q;
  assign instr_valid    = valid_q;
  assign misalign_err   = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - fetch_stage bench: directed scenarios plus randomized run against a stream model
module tb_fetch_stage;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] DEAD = 32'h0000_DEAD;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_f, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr_a, pc_a, pc4_a, instr_b, pc_b, pc4_b;
  logic        valid_a, mis_a, valid_b, mis_b;

  always #5 clk = ~clk;

  fetch_stage_if ifa ();
  fetch_stage_if ifb ();

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut_a (
    .clk(clk), .rst(rst), .stall_f(stall_f), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem(ifa), .Instr(instr_a), .PC(pc_a), .PC_plus4(pc4_a),
    .instr_valid(valid_a), .misalign_err(mis_a)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .rst(rst), .stall_f(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
    .imem(ifb), .Instr(instr_b), .PC(pc_b), .PC_plus4(pc4_b),
    .instr_valid(valid_b), .misalign_err(mis_b)
  );

  int checks = 0;
  int errors = 0;

  // memory A state
  bit          mem_pending, mem_dead, dead_next, ready_off;
  int          mem_cnt, ready_pct, lat_lo, lat_hi;
  logic [31:0] mem_addr;
  // reference model state
  logic [31:0] exp_pc, exp_req;
  int          since_rst, delivered, accepts_a;
  // memory B state
  bit          b_rvalid;
  logic [31:0] b_rdata;
  logic [31:0] b_accepts[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1111_1111;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_req"},   {31'b0, ifa.imem_req}, 32'd0);
    check({tag, "_addr"},  ifa.imem_addr, 32'h0);
    check({tag, "_valid"}, {31'b0, valid_a}, 32'd0);
    check({tag, "_instr"}, instr_a, NOP);
    check({tag, "_pc"},    pc_a, 32'h0);
    check({tag, "_pc4"},   pc4_a, 32'h4);
    check({tag, "_mis"},   {31'b0, mis_a}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stall_f = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    ifa.imem_ready = 1'b0; ifa.imem_rvalid = 1'b0; ifa.imem_rdata = 32'h0;
    ifb.imem_ready = 1'b0; ifb.imem_rvalid = 1'b0; ifb.imem_rdata = 32'h0;
    mem_pending = 1'b0; dead_next = 1'b0; b_rvalid = 1'b0; b_accepts.delete();
    exp_pc = 32'h0; exp_req = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("rst");
    check("rst_b_pc",   pc_b, 32'hFFFF_FFFC);
    check("rst_b_pc4",  pc4_b, 32'h0);
    check("rst_b_addr", ifb.imem_addr, 32'hFFFF_FFFC);
    rst = 1'b0;
    since_rst = 0;
  endtask

  // One clock: drive inputs, snapshot pre-edge outputs, advance, then update model and check.
  task automatic cycle(input bit st, input bit rd, input logic [31:0] rpc);
    logic        p_valid, p_req, p_b_req, rdy, rv, rd_eff;
    logic [31:0] p_instr, p_pc, p_pc4, p_addr, p_b_addr, tgt;
    rd_eff = rd && (since_rst > 0);
    stall_f = st; redirect = rd_eff; redirect_pc = rpc;
    rdy = !ready_off && ($urandom_range(99) < ready_pct);
    rv  = mem_pending && (mem_cnt == 0);
    ifa.imem_ready  = rdy;
    ifa.imem_rvalid = rv;
    ifa.imem_rdata  = rv ? (mem_dead ? DEAD : mem_word(mem_addr)) : $urandom;
    ifb.imem_ready  = 1'b1;
    ifb.imem_rvalid = b_rvalid;
    ifb.imem_rdata  = b_rdata;
    p_valid = valid_a; p_instr = instr_a; p_pc = pc_a; p_pc4 = pc4_a;
    p_req = ifa.imem_req; p_addr = ifa.imem_addr;
    p_b_req = ifb.imem_req; p_b_addr = ifb.imem_addr;
    @(posedge clk);
    #1;
    since_rst++;
    tgt = {rpc[31:2], 2'b00};

    if (rv && ifa.imem_req) mem_pending = 1'b0;
    else if (mem_pending && mem_cnt > 0) mem_cnt--;
    if (p_req && rdy) begin
      check("req_addr", p_addr, exp_req);
      exp_req = rd_eff ? tgt : exp_req + 32'd4;
      mem_pending = 1'b1;
      mem_cnt = $urandom_range(lat_hi, lat_lo);
      mem_addr = p_addr;
      mem_dead = dead_next;
      dead_next = 1'b0;
      accepts_a++;
    end else if (rd_eff) begin
      exp_req = tgt;
    end

    if (rd_eff) begin
      exp_pc = tgt;
      check("redir_flush", {31'b0, valid_a}, 32'd0);
      check("redir_mis", {31'b0, mis_a}, {31'b0, rpc[1:0] != 2'b00});
    end else begin
      check("mis_quiet", {31'b0, mis_a}, 32'd0);
      if (p_valid && !st) begin
        check("deliver_pc", p_pc, exp_pc);
        check("deliver_instr", p_instr, mem_word(p_pc));
        check("deliver_pc4", p_pc4, p_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end else if (p_valid && st) begin
        check("stall_valid", {31'b0, valid_a}, 32'd1);
        check("stall_instr", instr_a, p_instr);
        check("stall_pc", pc_a, p_pc);
        check("stall_pc4", pc4_a, p_pc4);
      end
    end
    if (!valid_a) check("nop_when_invalid", instr_a, NOP);

    b_rvalid = p_b_req;
    b_rdata  = mem_word(p_b_addr);
    if (p_b_req) b_accepts.push_back(p_b_addr);
  endtask

  initial begin
    int          acc0, d0;
    logic [31:0] rpc;
    ready_pct = 100; lat_lo = 0; lat_hi = 0; ready_off = 1'b0;
    delivered = 0; accepts_a = 0;
    do_reset();

    // zero-wait latency and throughput, plus wrap-around instance
    cycle(0, 0, 0);
    check("t1_req1", {31'b0, ifa.imem_req}, 32'd1);
    check("t1_addr0", ifa.imem_addr, 32'h0);
    cycle(0, 0, 0);
    check("t1_wait_invalid", {31'b0, valid_a}, 32'd0);
    cycle(0, 0, 0);
    check("t1_valid3", {31'b0, valid_a}, 32'd1);
    check("t1_instr0", instr_a, 32'h1111_1111);
    check("t1_pc0", pc_a, 32'h0);
    check("t1_pc4", pc4_a, 32'h4);
    check("t1_addr4", ifa.imem_addr, 32'h4);
    check("t6_b_valid", {31'b0, valid_b}, 32'd1);
    check("t6_b_pc", pc_b, 32'hFFFF_FFFC);
    check("t6_b_pc4", pc4_b, 32'h0);
    cycle(0, 0, 0);
    check("t1_consumed", {31'b0, valid_a}, 32'd0);
    cycle(0, 0, 0);
    check("t1_valid5", {31'b0, valid_a}, 32'd1);
    check("t1_pc_second", pc_a, 32'h4);
    check("t6_b_second_addr", (b_accepts.size() > 1) ? b_accepts[1] : 32'hFFFF_FFFF, 32'h0);

    // stall with PC=8 buffered
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    check("t2_pc8", pc_a, 32'h8);
    acc0 = accepts_a;
    repeat (4) cycle(1, 0, 0);
    check("t2_one_fetch", accepts_a - acc0, 32'd1);
    check("t2_pc_held", pc_a, 32'h8);
    cycle(0, 0, 0);
    check("t2_pc_c", pc_a, 32'hC);

    // redirect during WAIT; stale response is poisoned
    lat_lo = 2; lat_hi = 2;
    dead_next = 1'b1;
    cycle(1, 0, 0);
    cycle(1, 1, 32'h100);
    for (int i = 0; i < 12 && !ifa.imem_req; i++) begin
      cycle(0, 0, 0);
      check("t3_no_dead", {31'b0, instr_a == DEAD}, 32'd0);
      check("t3_invalid", {31'b0, valid_a}, 32'd0);
    end
    check("t3_req_seen", {31'b0, ifa.imem_req}, 32'd1);
    check("t3_addr", ifa.imem_addr, 32'h100);

    // redirect in REQ without and with acceptance
    ready_off = 1'b1;
    cycle(0, 1, 32'h300);
    check("t4_req_hold", {31'b0, ifa.imem_req}, 32'd1);
    check("t4_addr_switch", ifa.imem_addr, 32'h300);
    ready_off = 1'b0;
    lat_lo = 1; lat_hi = 1;
    dead_next = 1'b1;
    cycle(0, 1, 32'h400);
    for (int i = 0; i < 20 && !valid_a; i++) begin
      cycle(1, 0, 0);
      check("t4_no_dead", {31'b0, instr_a == DEAD}, 32'd0);
    end
    check("t4_valid", {31'b0, valid_a}, 32'd1);
    check("t4_pc", pc_a, 32'h400);
    check("t4_instr", instr_a, mem_word(32'h400));

    // misaligned redirect target
    cycle(0, 1, 32'h203);
    check("t5_mis_pulse", {31'b0, mis_a}, 32'd1);
    cycle(1, 0, 0);
    check("t5_mis_gone", {31'b0, mis_a}, 32'd0);
    for (int i = 0; i < 12 && !ifa.imem_req; i++) cycle(1, 0, 0);
    check("t5_addr", ifa.imem_addr, 32'h200);

    // randomized traffic
    d0 = delivered;
    for (int n = 0; n < 2000; n++) begin
      if (n % 250 == 0) begin
        ready_pct = $urandom_range(100, 30);
        lat_lo = 0;
        lat_hi = $urandom_range(3);
      end
      rpc = $urandom_range(32'hFFF, 0);
      if ($urandom_range(15) == 0) rpc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      if ($urandom_range(3) != 0) rpc[1:0] = 2'b00;
      cycle($urandom_range(99) < 30, $urandom_range(99) < 6, rpc);
    end
    check("rand_progress", {31'b0, (delivered - d0) > 50}, 32'd1);

    // asynchronous reset while waiting on memory
    ready_pct = 100; lat_lo = 3; lat_hi = 3;
    acc0 = accepts_a;
    for (int i = 0; i < 20 && accepts_a == acc0; i++) cycle(1, 0, 0);
    check("t6_in_wait", {31'b0, ifa.imem_req}, 32'd0);
    rst = 1'b1;
    #1;
    check_reset_values("t6_async");
    do_reset();
    lat_lo = 0; lat_hi = 0;
    repeat (3) cycle(0, 0, 0);
    check("t6_recover_valid", {31'b0, valid_a}, 32'd1);
    check("t6_recover_pc", pc_a, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
